byte_wb_master: RTL
===================

Name: byte_wb_master

Overview:
- Parametrised byte-serial-to-Wishbone-classic master: successor to the fixed 14-bit-address / 32-bit-data TT04 bridge.
- A CPU drives 3-bit commands plus an 8-bit data byte, one byte per cmd_stb pulse, to load address, write data and byte-select, then issue reads/writes.
- Adds configurable widths, auto-increment, WB error capture, a bus timeout, and explicit strobe-qualified commands (no command-edge detection).
- Sits between the tt_um pin wrapper and the on-chip Wishbone fabric.

Parameters:
- ADR_W, 14, word-address width (byte address bits [1:0] implicit); 1..32.
- DAT_W, 32, data width; multiple of 8, 8..64. SEL_W = DAT_W/8, DAT_BYTES = SEL_W, ADR_BYTES = ceil(ADR_W/8).
- TIMEOUT, 255, cycles STB may wait for ACK/ERR; 0 disables timeout.

Ports:
- clk, input, 1, sole clock, rising edge.
- rst, input, 1, synchronous, active-high reset.
- cmd, input, 3, command code; sampled only when cmd_stb=1.
- cmd_stb, input, 1, one-cycle command strobe.
- din, input, 8, command operand byte.
- dout, output, 8, registered read-back byte.
- busy, output, 1, transaction in flight (state ACTIVE).
- valid, output, 1, last transaction completed; sticky until next issue.
- err, output, 1, last transaction ended in wb_ERR or timeout.
- tmo, output, 1, last transaction ended by timeout.
- wb_CYC, output, 1, Wishbone cycle.
- wb_STB, output, 1, Wishbone strobe.
- wb_WE, output, 1, write enable.
- wb_ADR, output, ADR_W, word address.
- wb_SEL, output, SEL_W, byte lane select.
- wb_DAT_MOSI, output, DAT_W, write data.
- wb_DAT_MISO, input, DAT_W, read data.
- wb_ACK, input, 1, slave acknowledge.
- wb_ERR, input, 1, slave error.

Behaviour:
- Reset (rst=1, or EXEC 0x01): all outputs 0; internal ADR, DO, DI, hold, all byte pointers 0; SEL register all-ones; FSM = IDLE. EXEC 0x01 is accepted in any state and aborts an in-flight cycle (STB/CYC drop on the next edge).
- Commands (acted on only when cmd_stb=1):
  - 0 NOP: no effect.
  - 1 EXEC, opcode in din:
    - 0x04: hold <= 0.
    - 0x05: hold <= 1.
    - 0x06: read.
    - 0x07: write.
    - 0x16: read with post-increment.
    - 0x17: write with post-increment.
    - Any other opcode: ignored.
  - 2 ADR: ADR byte[adr_ptr] <= din; adr_ptr increments and wraps at ADR_BYTES. Bits above ADR_W are discarded.
  - 3 DO: DO byte[do_ptr] <= din; do_ptr wraps at DAT_BYTES.
  - 4 DI: dout <= DI byte[di_ptr] on the next edge; di_ptr wraps at DAT_BYTES.
  - 5 SEL: SEL register <= din[SEL_W-1:0]. For DAT_W=64, all 8 bits are used.
  - 6 PTR: adr_ptr, do_ptr and di_ptr all <= 0.
  - 7: reserved, ignored.
- FSM IDLE:
  - wb_STB=0, busy=0.
  - wb_CYC=hold.
  - All commands are accepted.
  - A read/write EXEC moves the FSM to ACTIVE on the next edge. On that same edge: wb_STB=1, wb_CYC=1, valid=0, err=0, tmo=0, timeout counter=0.
  - wb_WE=1 for a write; wb_SEL = SEL register on a write, all-ones on a read.
- FSM ACTIVE:
  - busy=1.
  - Every command except EXEC 0x01 is ignored (no side effects, including pointers).
  - Outputs wb_ADR, wb_DAT_MOSI, wb_SEL and wb_WE stay stable.
- Termination in ACTIVE, priority soft-reset > ACK > ERR > timeout:
  - wb_ACK=1: DI <= wb_DAT_MISO if read; valid=1; FSM -> IDLE. If auto-increment, ADR <= ADR+1 mod 2^ADR_W.
  - wb_ERR=1 (without ACK): valid=1, err=1, no increment, DI unchanged.
  - Timeout (TIMEOUT!=0, counter reaches TIMEOUT-1 with no ACK/ERR): valid=1, err=1, tmo=1.
  - In all three cases wb_STB and wb_WE drop on the same edge. wb_CYC drops too unless hold=1.
- Latency:
  - cmd_stb to wb_STB: 1 cycle.
  - ACK to valid=1: 1 cycle.
  - Minimum transaction, single-cycle ACK: 3 clocks from EXEC strobe to valid.
- ACK asserted while in IDLE is ignored.

Test Plan:
- Defaults: ADR 0x34, 0x12; DO 0xEF, 0xBE, 0xAD, 0xDE; EXEC 0x07; slave ACKs in 2 cycles -> wb_ADR=0x1234, MOSI=0xDEADBEEF, SEL=0xF, WE=1; valid=1 on the 4th clock after the strobe; CYC drops.
- Read, slave returns 0xCAFEF00D: EXEC 0x06, then PTR, then DI x4 -> dout sequence 0x0D, 0xF0, 0xFE, 0xCA; a 5th DI wraps back to 0x0D.
- EXEC 0x16 three times at ADR=0x3FFF -> addresses 0x3FFF, 0x0000, 0x0001; final ADR=0x0002.
- No slave response -> STB held exactly 255 cycles, then err=1, tmo=1, valid=1; ADR not incremented.
- wb_ERR in the same cycle as ACK -> ACK wins, err=0. wb_ERR alone -> err=1, tmo=0. ADR/DO strobes while busy -> registers unchanged.
- EXEC 0x05, two writes, EXEC 0x04 -> CYC stays high across both writes and falls 1 cycle after 0x04. EXEC 0x01 during ACTIVE -> STB/CYC=0 next edge, all state reset. rst high mid-transaction -> the same reset result.

Source files
------------

// File: rtl/byte_wb_master_if.sv
// Wishbone classic bus bundle between byte_wb_master and the on-chip fabric.
// Widths follow the master's ADR_W / DAT_W parameters.
interface byte_wb_master_if #(
    parameter int ADR_W = 14,
    parameter int DAT_W = 32
);
    localparam int SEL_W = DAT_W / 8;

    logic             wb_CYC;
    logic             wb_STB;
    logic             wb_WE;
    logic [ADR_W-1:0] wb_ADR;
    logic [SEL_W-1:0] wb_SEL;
    logic [DAT_W-1:0] wb_DAT_MOSI;
    logic [DAT_W-1:0] wb_DAT_MISO;
    logic             wb_ACK;
    logic             wb_ERR;

    modport master (
        output wb_CYC, wb_STB, wb_WE, wb_ADR, wb_SEL, wb_DAT_MOSI,
        input  wb_DAT_MISO, wb_ACK, wb_ERR
    );

    modport slave (
        input  wb_CYC, wb_STB, wb_WE, wb_ADR, wb_SEL, wb_DAT_MOSI,
        output wb_DAT_MISO, wb_ACK, wb_ERR
    );
endinterface

// File: rtl/byte_wb_master.sv
// Byte-serial command port to Wishbone classic master: a CPU loads address,
// data and lane select one byte at a time, then issues single reads/writes.
module byte_wb_master #(
    parameter int ADR_W   = 14,
    parameter int DAT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] cmd,
    input  logic       cmd_stb,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       busy,
    output logic       valid,
    output logic       err,
    output logic       tmo,
    byte_wb_master_if.master wb
);
    localparam int SEL_W     = DAT_W / 8;
    localparam int DAT_BYTES = SEL_W;
    localparam int ADR_BYTES = (ADR_W + 7) / 8;
    localparam int AP_W      = (ADR_BYTES > 1) ? $clog2(ADR_BYTES) : 1;
    localparam int DP_W      = (DAT_BYTES > 1) ? $clog2(DAT_BYTES) : 1;
    localparam int CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [AP_W-1:0]  AP_LAST  = AP_W'(ADR_BYTES - 1);
    localparam logic [DP_W-1:0]  DP_LAST  = DP_W'(DAT_BYTES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [2:0] C_EXEC = 3'd1;
    localparam logic [2:0] C_ADR  = 3'd2;
    localparam logic [2:0] C_DO   = 3'd3;
    localparam logic [2:0] C_DI   = 3'd4;
    localparam logic [2:0] C_SEL  = 3'd5;
    localparam logic [2:0] C_PTR  = 3'd6;

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t           state_q, state_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [DAT_W-1:0] do_q, do_d;
    logic [DAT_W-1:0] di_q, di_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [AP_W-1:0]  adr_ptr_q, adr_ptr_d;
    logic [DP_W-1:0]  do_ptr_q, do_ptr_d;
    logic [DP_W-1:0]  di_ptr_q, di_ptr_d;
    logic [7:0]       dout_q, dout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hold_q, hold_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             tmo_q, tmo_d;
    logic             we_q, we_d;
    logic             inc_q, inc_d;

    logic exec_stb, soft_rst, issue, tmo_hit, done;

    // Soft reset is honoured in every state, so it bypasses the FSM entirely.
    assign exec_stb = cmd_stb && (cmd == C_EXEC);
    assign soft_rst = exec_stb && (din == 8'h01);
    assign issue    = (state_q == S_IDLE) && exec_stb &&
                      ((din == 8'h06) || (din == 8'h07) || (din == 8'h16) || (din == 8'h17));
    assign tmo_hit  = (TIMEOUT != 0) && (cnt_q == TMO_LAST);
    assign done     = (state_q == S_ACTIVE) && (wb.wb_ACK || wb.wb_ERR || tmo_hit);

    always_ff @(posedge clk) begin
        if (rst || soft_rst) state_q <= S_IDLE;
        else                 state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (issue) state_d = S_ACTIVE;
            S_ACTIVE: if (done)  state_d = S_IDLE;
            default:             state_d = S_IDLE;
        endcase
    end

    always_comb begin
        adr_d     = adr_q;
        do_d      = do_q;
        di_d      = di_q;
        sel_d     = sel_q;
        hold_d    = hold_q;
        adr_ptr_d = adr_ptr_q;
        do_ptr_d  = do_ptr_q;
        di_ptr_d  = di_ptr_q;
        dout_d    = dout_q;
        valid_d   = valid_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        we_d      = we_q;
        inc_d     = inc_q;
        cnt_d     = cnt_q;
        if (state_q == S_IDLE) begin
            if (issue) begin
                we_d    = din[0];
                inc_d   = din[4];
                valid_d = 1'b0;
                err_d   = 1'b0;
                tmo_d   = 1'b0;
                cnt_d   = '0;
            end else if (cmd_stb) begin
                case (cmd)
                    C_EXEC: begin
                        if (din == 8'h04)      hold_d = 1'b0;
                        else if (din == 8'h05) hold_d = 1'b1;
                    end
                    C_ADR: begin
                        for (int b = 0; b < ADR_W; b++)
                            if (b / 8 == int'(adr_ptr_q)) adr_d[b] = din[b % 8];
                        adr_ptr_d = (adr_ptr_q == AP_LAST) ? '0 : adr_ptr_q + AP_W'(1);
                    end
                    C_DO: begin
                        for (int b = 0; b < DAT_W; b++)
                            if (b / 8 == int'(do_ptr_q)) do_d[b] = din[b % 8];
                        do_ptr_d = (do_ptr_q == DP_LAST) ? '0 : do_ptr_q + DP_W'(1);
                    end
                    C_DI: begin
                        for (int k = 0; k < DAT_BYTES; k++)
                            if (k == int'(di_ptr_q)) dout_d = di_q[8*k +: 8];
                        di_ptr_d = (di_ptr_q == DP_LAST) ? '0 : di_ptr_q + DP_W'(1);
                    end
                    C_SEL: sel_d = din[SEL_W-1:0];
                    C_PTR: begin
                        adr_ptr_d = '0;
                        do_ptr_d  = '0;
                        di_ptr_d  = '0;
                    end
                    default: ;
                endcase
            end
        end else if (wb.wb_ACK) begin
            if (!we_q) di_d  = wb.wb_DAT_MISO;
            if (inc_q) adr_d = adr_q + ADR_W'(1);
            valid_d = 1'b1;
        end else if (wb.wb_ERR) begin
            valid_d = 1'b1;
            err_d   = 1'b1;
        end else if (tmo_hit) begin
            valid_d = 1'b1;
            err_d   = 1'b1;
            tmo_d   = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
            adr_q     <= '0;
            do_q      <= '0;
            di_q      <= '0;
            sel_q     <= '1;
            hold_q    <= 1'b0;
            adr_ptr_q <= '0;
            do_ptr_q  <= '0;
            di_ptr_q  <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
            we_q      <= 1'b0;
            inc_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            adr_q     <= adr_d;
            do_q      <= do_d;
            di_q      <= di_d;
            sel_q     <= sel_d;
            hold_q    <= hold_d;
            adr_ptr_q <= adr_ptr_d;
            do_ptr_q  <= do_ptr_d;
            di_ptr_q  <= di_ptr_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            we_q      <= we_d;
            inc_q     <= inc_d;
            cnt_q     <= cnt_d;
        end
    end

    // Reads always present every byte lane; only writes honour the SEL register.
    always_comb begin
        busy           = (state_q == S_ACTIVE);
        wb.wb_STB      = (state_q == S_ACTIVE);
        wb.wb_CYC      = (state_q == S_ACTIVE) || hold_q;
        wb.wb_WE       = (state_q == S_ACTIVE) && we_q;
        wb.wb_SEL      = '0;
        if (state_q == S_ACTIVE) wb.wb_SEL = we_q ? sel_q : {SEL_W{1'b1}};
        wb.wb_ADR      = adr_q;
        wb.wb_DAT_MOSI = do_q;
        dout           = dout_q;
        valid          = valid_q;
        err            = err_q;
        tmo            = tmo_q;
    end
endmodule
